// File: rtl/sprite_palette_bank_if.sv
// Bus bundle for sprite_palette_bank: palette writes, pixel lookups, effect control and results.
// The master side drives requests; the slave side is the palette bank.
interface sprite_palette_bank_if #(
  parameter int IDX_W   = 4,
  parameter int PAL_W   = 2,
  parameter int COLOR_W = 4
);
  logic                   frame_tick;
  logic                   wr_en;
  logic [PAL_W-1:0]       wr_pal;
  logic [IDX_W-1:0]       wr_idx;
  logic [3*COLOR_W-1:0]   wr_data;
  logic                   pix_valid;
  logic [PAL_W-1:0]       pix_pal;
  logic [IDX_W-1:0]       pix_idx;
  logic                   out_valid;
  logic [COLOR_W-1:0]     red;
  logic [COLOR_W-1:0]     green;
  logic [COLOR_W-1:0]     blue;
  logic                   transparent;
  logic                   fx_start;
  logic [1:0]             fx_mode;
  logic                   fx_busy;

  modport master (
    output frame_tick, wr_en, wr_pal, wr_idx, wr_data,
    output pix_valid, pix_pal, pix_idx, fx_start, fx_mode,
    input  out_valid, red, green, blue, transparent, fx_busy
  );

  modport slave (
    input  frame_tick, wr_en, wr_pal, wr_idx, wr_data,
    input  pix_valid, pix_pal, pix_idx, fx_start, fx_mode,
    output out_valid, red, green, blue, transparent, fx_busy
  );
endinterface

// File: rtl/sprite_palette_bank.sv
// Multi-palette sprite colour lookup with colour-key flag and frame-stepped
// flash / fade-out / fade-in screen effects; two-cycle fully pipelined lookup.
module sprite_palette_bank #(
  parameter int IDX_W        = 4,
  parameter int NUM_PAL      = 4,
  parameter int COLOR_W      = 4,
  parameter int TRANSP_IDX   = 0,
  parameter int FLASH_FRAMES = 4
) (
  input logic                  Clk,
  input logic                  Reset,
  sprite_palette_bank_if.slave bus
);

  localparam int ENTRIES = 2**IDX_W;
  localparam int RGB_W   = 3*COLOR_W;
  localparam logic [COLOR_W-1:0] LVL_MAX    = '1;
  localparam logic [7:0]         FLASH_LAST = 8'(FLASH_FRAMES);
  localparam logic [IDX_W-1:0]   KEY_IDX    = IDX_W'(TRANSP_IDX);

  typedef enum logic [2:0] {IDLE, FLASH, FADE_OUT, DARK, FADE_IN} fx_state_e;

  // Widen a 4-bit nibble to COLOR_W by repeating its bits MSB first.
  function automatic logic [COLOR_W-1:0] scale_nib(input logic [3:0] nib);
    logic [COLOR_W-1:0] s;
    s = '0;
    for (int i = 0; i < COLOR_W; i++) s[COLOR_W-1-i] = nib[3-(i%4)];
    return s;
  endfunction

  function automatic logic [RGB_W-1:0] default_entry(input int idx);
    case (idx)
      0:       return {scale_nib(4'hF), scale_nib(4'hF), scale_nib(4'hF)};
      2:       return {scale_nib(4'h6), scale_nib(4'hD), scale_nib(4'hF)};
      default: return '0;
    endcase
  endfunction

  function automatic logic [COLOR_W-1:0] sat_sub(input logic [COLOR_W-1:0] c,
                                                 input logic [COLOR_W-1:0] lvl);
    logic signed [COLOR_W:0] diff;
    diff = $signed({1'b0, c}) - $signed({1'b0, lvl});
    return (diff < 0) ? '0 : diff[COLOR_W-1:0];
  endfunction

  function automatic logic [RGB_W-1:0] apply_fx(input logic [RGB_W-1:0] rgb,
                                                input fx_state_e st,
                                                input logic [COLOR_W-1:0] lvl);
    case (st)
      FLASH:                   return '1;
      FADE_OUT, DARK, FADE_IN: return {sat_sub(rgb[3*COLOR_W-1 -: COLOR_W], lvl),
                                       sat_sub(rgb[2*COLOR_W-1 -: COLOR_W], lvl),
                                       sat_sub(rgb[COLOR_W-1:0], lvl)};
      default:                 return rgb;
    endcase
  endfunction

  logic [RGB_W-1:0] pal_q [NUM_PAL][ENTRIES];
  logic [RGB_W-1:0] pal_d [NUM_PAL][ENTRIES];

  logic             vld_p1_q, vld_p1_d, key_p1_q, key_p1_d;
  logic [RGB_W-1:0] rgb_p1_q, rgb_p1_d;
  logic             vld_p2_q, vld_p2_d, key_p2_q, key_p2_d;
  logic [RGB_W-1:0] rgb_p2_q, rgb_p2_d;

  fx_state_e          state_q, state_d;
  logic [COLOR_W-1:0] level_q, level_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               busy_q, busy_d;

  always_comb begin
    pal_d = pal_q;
    if (bus.wr_en && (int'(bus.wr_pal) < NUM_PAL)) pal_d[bus.wr_pal][bus.wr_idx] = bus.wr_data;
  end

  // Stage 1: read-first palette access, colour-key match, valid
  always_comb begin
    vld_p1_d = bus.pix_valid;
    key_p1_d = (bus.pix_idx == KEY_IDX);
    rgb_p1_d = '0;
    if (int'(bus.pix_pal) < NUM_PAL) rgb_p1_d = pal_q[bus.pix_pal][bus.pix_idx];
  end

  // Stage 2: effect applied with the FSM state current at this stage; hold when idle
  always_comb begin
    vld_p2_d = vld_p1_q;
    rgb_p2_d = rgb_p2_q;
    key_p2_d = key_p2_q;
    if (vld_p1_q) begin
      rgb_p2_d = apply_fx(rgb_p1_q, state_q, level_q);
      key_p2_d = key_p1_q;
    end
  end

  // Accepted start requests take priority over a coincident frame_tick.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.fx_start && bus.fx_mode == 2'b00) begin
          state_d     = FLASH;
          frame_cnt_d = '0;
        end else if (bus.fx_start && bus.fx_mode == 2'b01) begin
          state_d = FADE_OUT;
          level_d = '0;
        end
      end
      FLASH: if (bus.frame_tick) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        if (frame_cnt_d == FLASH_LAST) state_d = IDLE;
      end
      FADE_OUT: if (bus.frame_tick) begin
        if (level_q != LVL_MAX) level_d = level_q + 1'b1;
        if (level_d == LVL_MAX) state_d = DARK;
      end
      DARK: if (bus.fx_start && bus.fx_mode == 2'b10) state_d = FADE_IN;
      FADE_IN: if (bus.frame_tick) begin
        if (level_q != '0) level_d = level_q - 1'b1;
        if (level_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FLASH) || (state_d == FADE_OUT) || (state_d == FADE_IN);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int p = 0; p < NUM_PAL; p++)
        for (int e = 0; e < ENTRIES; e++) pal_q[p][e] <= default_entry(e);
      vld_p1_q    <= 1'b0;
      key_p1_q    <= 1'b0;
      rgb_p1_q    <= '0;
      vld_p2_q    <= 1'b0;
      key_p2_q    <= 1'b0;
      rgb_p2_q    <= '0;
      state_q     <= IDLE;
      level_q     <= '0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      pal_q       <= pal_d;
      vld_p1_q    <= vld_p1_d;
      key_p1_q    <= key_p1_d;
      rgb_p1_q    <= rgb_p1_d;
      vld_p2_q    <= vld_p2_d;
      key_p2_q    <= key_p2_d;
      rgb_p2_q    <= rgb_p2_d;
      state_q     <= state_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.out_valid   = vld_p2_q;
  assign bus.red         = rgb_p2_q[3*COLOR_W-1 -: COLOR_W];
  assign bus.green       = rgb_p2_q[2*COLOR_W-1 -: COLOR_W];
  assign bus.blue        = rgb_p2_q[COLOR_W-1:0];
  assign bus.transparent = key_p2_q;
  assign bus.fx_busy     = busy_q;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed and randomized bench for sprite_palette_bank against a behavioural
// palette/effect reference model.
module tb_sprite_palette_bank;
  localparam int IDX_W   = 4;
  localparam int NUM_PAL = 4;
  localparam int PAL_W   = 2;
  localparam int COLOR_W = 4;

  localparam int M_IDLE = 0, M_FLASH = 1, M_FOUT = 2, M_DARK = 3, M_FIN = 4;

  typedef struct {
    bit          v;
    logic [11:0] rgb;
    bit          t;
  } pix_t;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  sprite_palette_bank_if #(.IDX_W(IDX_W), .PAL_W(PAL_W), .COLOR_W(COLOR_W)) bus ();

  sprite_palette_bank #(
    .IDX_W(IDX_W), .NUM_PAL(NUM_PAL), .COLOR_W(COLOR_W),
    .TRANSP_IDX(0), .FLASH_FRAMES(4)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  logic [11:0] pal_m [NUM_PAL][16];
  int          m_st, m_lvl, m_frames;
  pix_t        pipe_q[$];
  logic [11:0] held_rgb;
  bit          held_t;
  int          n_chk  = 0;
  int          n_fail = 0;

  bit          w_en, f_start, f_tick;
  logic [1:0]  w_pal, f_mode;
  logic [3:0]  w_idx;
  logic [11:0] w_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Colour as seen on screen: white during flash, otherwise darkened by the fade level.
  function automatic logic [11:0] fx_view(input logic [11:0] c);
    logic [11:0] r;
    int v;
    if (m_st == M_FLASH) return 12'hFFF;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      v = int'(c[ch*4 +: 4]) - m_lvl;
      r[ch*4 +: 4] = (v < 0) ? 4'h0 : v[3:0];
    end
    return r;
  endfunction

  task automatic model_defaults();
    for (int p = 0; p < NUM_PAL; p++)
      for (int e = 0; e < 16; e++)
        pal_m[p][e] = (e == 0) ? 12'hFFF : (e == 2) ? 12'h6DF : 12'h000;
    m_st = M_IDLE; m_lvl = 0; m_frames = 0;
    held_rgb = '0; held_t = 1'b0;
    pipe_q.delete();
    pipe_q.push_back('{1'b0, 12'h000, 1'b0});
  endtask

  task automatic model_fx();
    if (f_start && ((m_st == M_IDLE && f_mode inside {2'd0, 2'd1}) ||
                    (m_st == M_DARK && f_mode == 2'd2))) begin
      if (f_mode == 2'd0)      begin m_st = M_FLASH; m_frames = 0; end
      else if (f_mode == 2'd1) begin m_st = M_FOUT;  m_lvl = 0;    end
      else                     m_st = M_FIN;
    end else if (f_tick) begin
      case (m_st)
        M_FLASH: begin m_frames++; if (m_frames == 4) m_st = M_IDLE; end
        M_FOUT:  begin m_lvl = (m_lvl < 15) ? m_lvl + 1 : 15; if (m_lvl == 15) m_st = M_DARK; end
        M_FIN:   begin m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;   if (m_lvl == 0)  m_st = M_IDLE; end
        default: ;
      endcase
    end
  endtask

  // One clock: drive a lookup plus the pending write/effect stimulus, then check outputs.
  task automatic issue(input bit v, input int p, input int x, input string tag);
    pix_t e;
    pipe_q.push_back('{v, pal_m[p][x], (x == 0)});
    bus.pix_valid  = v;
    bus.pix_pal    = PAL_W'(p);
    bus.pix_idx    = IDX_W'(x);
    bus.wr_en      = w_en;
    bus.wr_pal     = w_pal;
    bus.wr_idx     = w_idx;
    bus.wr_data    = w_data;
    bus.fx_start   = f_start;
    bus.fx_mode    = f_mode;
    bus.frame_tick = f_tick;
    @(posedge Clk); #1;
    e = pipe_q.pop_front();
    if (e.v) begin held_rgb = fx_view(e.rgb); held_t = e.t; end
    chk({tag, ".vld"}, 32'(bus.out_valid), 32'(e.v));
    chk({tag, ".rgb"}, {20'h0, bus.red, bus.green, bus.blue}, {20'h0, held_rgb});
    chk({tag, ".key"}, 32'(bus.transparent), 32'(held_t));
    if (w_en) pal_m[w_pal][w_idx] = w_data;
    model_fx();
    chk({tag, ".busy"}, 32'(bus.fx_busy), 32'(m_st == M_FLASH || m_st == M_FOUT || m_st == M_FIN));
    w_en = 1'b0; f_start = 1'b0; f_tick = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) issue(1'b0, 0, 0, tag);
  endtask

  task automatic do_reset(input bit junk);
    Reset          = 1'b1;
    bus.wr_en      = junk;
    bus.wr_pal     = 2'd2;
    bus.wr_idx     = 4'd5;
    bus.wr_data    = 12'h123;
    bus.pix_valid  = junk;
    bus.pix_pal    = 2'd0;
    bus.pix_idx    = 4'd2;
    bus.fx_start   = junk;
    bus.fx_mode    = 2'd1;
    bus.frame_tick = junk;
    @(posedge Clk); #1;
    Reset          = 1'b0;
    bus.wr_en      = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.fx_start   = 1'b0;
    bus.frame_tick = 1'b0;
    model_defaults();
    chk("rst.vld",  32'(bus.out_valid), 32'd0);
    chk("rst.rgb",  {20'h0, bus.red, bus.green, bus.blue}, 32'd0);
    chk("rst.key",  32'(bus.transparent), 32'd0);
    chk("rst.busy", 32'(bus.fx_busy), 32'd0);
  endtask

  initial begin
    w_en = 1'b0; f_start = 1'b0; f_tick = 1'b0;
    w_pal = '0; w_idx = '0; w_data = '0; f_mode = '0;
    do_reset(1'b0);
    do_reset(1'b0);

    // Defaults streamed back-to-back
    issue(1'b1, 0, 0, "t1_idx0");
    issue(1'b1, 0, 1, "t1_idx1");
    issue(1'b1, 0, 2, "t1_idx2");
    idle(3, "t1_drain");

    // Write with same-cycle and next-cycle reads
    w_en = 1'b1; w_pal = 2'd2; w_idx = 4'd5; w_data = 12'hA3C;
    issue(1'b1, 2, 5, "t2_same");
    issue(1'b1, 2, 5, "t2_next");
    issue(1'b1, 0, 5, "t2_pal0");
    idle(2, "t2_drain");

    // Flash for four frames
    f_start = 1'b1; f_mode = 2'd0;
    issue(1'b1, 0, 0, "t3_start");
    for (int i = 0; i < 4; i++) begin f_tick = 1'b1; issue(1'b1, 0, 2, "t3_tick"); end
    idle(2, "t3_drain");

    // Fade out to dark, ignored requests while dark, fade back in
    f_start = 1'b1; f_mode = 2'd1;
    issue(1'b1, 0, 2, "t4_fo");
    for (int i = 0; i < 15; i++) begin f_tick = 1'b1; issue(1'b1, 0, 2, "t4_fo_tick"); end
    f_tick = 1'b1;                  issue(1'b1, 2, 5, "t4_dark_tick");
    f_start = 1'b1; f_mode = 2'd0;  issue(1'b1, 0, 2, "t4_dark_flash");
    f_start = 1'b1; f_mode = 2'd1;  issue(1'b1, 0, 0, "t4_dark_fo");
    f_start = 1'b1; f_mode = 2'd2;  issue(1'b1, 0, 2, "t4_fi");
    for (int i = 0; i < 15; i++) begin f_tick = 1'b1; issue(1'b1, 0, 2, "t4_fi_tick"); end
    idle(2, "t4_drain");

    // Ignored requests and start coinciding with a frame tick
    f_start = 1'b1; f_mode = 2'd2;                issue(1'b1, 0, 2, "t5_fi_idle");
    f_start = 1'b1; f_mode = 2'd3;                issue(1'b1, 0, 2, "t5_mode3");
    f_start = 1'b1; f_mode = 2'd0; f_tick = 1'b1; issue(1'b1, 0, 0, "t5_start_tick");
    f_start = 1'b1; f_mode = 2'd1;                issue(1'b1, 0, 2, "t5_fo_in_flash");
    for (int i = 0; i < 4; i++) begin f_tick = 1'b1; issue(1'b1, 0, 2, "t5_tick"); end
    idle(2, "t5_drain");

    // Reset in the middle of a fade and a write
    f_start = 1'b1; f_mode = 2'd1;
    issue(1'b1, 0, 2, "t6_fo");
    for (int i = 0; i < 7; i++) begin f_tick = 1'b1; issue(1'b1, 0, 2, "t6_tick"); end
    do_reset(1'b1);
    issue(1'b1, 2, 5, "t6_pal2");
    issue(1'b1, 0, 2, "t6_pal0");
    idle(2, "t6_drain");

    // Randomized writes, lookups and effect traffic
    for (int i = 0; i < 500; i++) begin
      w_en    = ($urandom_range(0, 3) == 0);
      w_pal   = 2'($urandom_range(0, 3));
      w_idx   = 4'($urandom_range(0, 15));
      w_data  = 12'($urandom_range(0, 4095));
      f_start = ($urandom_range(0, 7) == 0);
      f_mode  = 2'($urandom_range(0, 3));
      f_tick  = ($urandom_range(0, 2) == 0);
      issue(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), "rnd");
    end
    idle(2, "rnd_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
